write_addr_seq: RTL and testbench
=================================

WRITE_ADDR_SEQ -- requirements
Module: write_addr_seq

Interface
REQ-001 Parameter DEPTH, default 15, is the number of writable register slots in the sequence; legal range 2..256.
REQ-002 Parameter AW, default 4, is the width of the encoded write address.
REQ-003 Parameter BASE, default 1, is the address emitted for slot 0; BASE+DEPTH-1 SHALL be at most 2^AW-1, and the block SHALL fail elaboration otherwise.
REQ-004 Parameter WRAP, default 1: 1 = wrap-around sequencing; 0 = saturate and report done.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 Start  input  1  advance enable; slot advances one position per clock while high.
REQ-008 clear  input  1  synchronous return to slot 0.
REQ-009 load  input  1  synchronous load of slot index from load_idx.
REQ-010 load_idx  input  8  slot index to load.
REQ-011 WriteReg  output  AW  encoded write address = BASE + current slot index.
REQ-012 wrap  output  1  one-cycle pulse marking a wrap from slot DEPTH-1 to slot 0.
REQ-013 done  output  1  sticky flag: saturate mode has reached slot DEPTH-1 and Start was sampled high there.
REQ-014 busy  output  1  high while Start is high and done is low.

Function
REQ-015 Internal state: slot index idx (0..DEPTH-1), a one-hot ring equivalent, and a two-state FSM {RUN, DONE}.
REQ-016 WriteReg SHALL be combinational from registered idx: zero added latency, glitch-free relative to clk.
REQ-017 Control priority per edge: clear > load > Start; at most one action per cycle.
REQ-018 clear=1 -> idx=0, FSM=RUN, done=0, wrap=0 on the next cycle.
REQ-019 load=1 -> idx=load_idx, FSM=RUN, done=0; load_idx >= DEPTH SHALL be clamped to DEPTH-1.
REQ-020 Start=1 in RUN with idx<DEPTH-1 -> idx=idx+1.
REQ-021 Start=1 in RUN with idx=DEPTH-1 and WRAP=1 -> idx=0; wrap=1 for exactly the following cycle.
REQ-022 Start=1 in RUN with idx=DEPTH-1 and WRAP=0 -> idx holds; FSM=DONE; done=1 from the following cycle.
REQ-023 DONE: idx holds regardless of Start; only clear, load or reset leave DONE.
REQ-024 Start=0 -> idx, FSM and done hold; wrap=0.
REQ-025 With WRAP=1, done SHALL remain 0 permanently.
REQ-026 wrap SHALL never be asserted on two consecutive cycles unless DEPTH consecutive advances have occurred.

Reset
REQ-027 rst_n low asynchronously forces idx=0, FSM=RUN, done=0, wrap=0; WriteReg therefore equals BASE.
REQ-028 Reset asserted mid-sequence or mid-wrap SHALL abort the operation with no residual wrap pulse.
REQ-029 Leaving reset, the first advance occurs on the first rising edge with rst_n high and Start high.

Configuration
REQ-030 Macro WRITE_ADDR_SEQ_ONEHOT_EN, when defined, adds output slot_oh [DEPTH], a registered one-hot copy of idx (bit idx high) with identical reset, clear and load behaviour.
REQ-031 With WRITE_ADDR_SEQ_ONEHOT_EN undefined, port slot_oh SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then Start=1 for 16 cycles (defaults) -> WriteReg goes 1,2,...,15,1; wrap=1 only in the cycle WriteReg returns to 1.
REQ-033 WRAP=0, DEPTH=4, BASE=0, Start held high -> WriteReg 0,1,2,3,3...; done=1 from the cycle after the first Start at 3; busy=0 thereafter.
REQ-034 load=1, load_idx=200 (defaults) -> WriteReg=15; load together with clear in the same cycle -> WriteReg=1 (clear wins).
REQ-035 rst_n pulsed low between clock edges while WriteReg=9 -> WriteReg=1 immediately, wrap=0, done=0.
REQ-036 Start toggled 1,0,1,0 from reset -> WriteReg 1,2,2,3,3; no wrap.
REQ-037 WRITE_ADDR_SEQ_ONEHOT_EN defined, rerun REQ-032 -> slot_oh = 1<<(WriteReg-BASE) on every cycle.

Source files
------------

// File: rtl/write_addr_seq.sv
// Write-address sequencer: steps a slot index through DEPTH register slots and
// emits BASE+slot. Optional one-hot slot output is enabled by WRITE_ADDR_SEQ_ONEHOT_EN.
module write_addr_seq #(
    parameter int DEPTH = 15,
    parameter int AW    = 4,
    parameter int BASE  = 1,
    parameter int WRAP  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Start,
    input  logic          clear,
    input  logic          load,
    input  logic [7:0]    load_idx,
    output logic [AW-1:0] WriteReg,
    output logic          wrap,
    output logic          done,
    output logic          busy,
    output logic          dbg_state_o
`ifdef WRITE_ADDR_SEQ_ONEHOT_EN
    ,
    output logic [DEPTH-1:0] slot_oh
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);
    localparam logic [AW-1:0] BASE_A   = AW'(BASE);

    generate
        if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
            $error("write_addr_seq: DEPTH must be within 2..256");
        end
        if (BASE < 0 || (BASE + DEPTH - 1) > ((2 ** AW) - 1)) begin : g_bad_base
            $error("write_addr_seq: BASE+DEPTH-1 does not fit in AW bits");
        end
    endgenerate

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          wrap_q;
    logic          done_q;
    logic [IW-1:0] load_slot_d;

    // Out-of-range load indices park on the last slot; compare in 9 bits so DEPTH=256 works.
    assign load_slot_d = ({1'b0, load_idx} >= 9'(DEPTH)) ? IDX_LAST : IW'(load_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (clear) begin
                state_q <= S_RUN;
                idx_q   <= '0;
                done_q  <= 1'b0;
            end else if (load) begin
                state_q <= S_RUN;
                idx_q   <= load_slot_d;
                done_q  <= 1'b0;
            end else if (Start && state_q == S_RUN) begin
                if (idx_q != IDX_LAST) begin
                    idx_q <= idx_q + IW'(1);
                end else if (WRAP != 0) begin
                    idx_q  <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

`ifdef WRITE_ADDR_SEQ_ONEHOT_EN
    logic [DEPTH-1:0] oh_q;

    // Ring copy of idx_q: a rotate covers both the step and the wrap to slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oh_q <= DEPTH'(1);
        end else if (clear) begin
            oh_q <= DEPTH'(1);
        end else if (load) begin
            oh_q <= DEPTH'(1) << load_slot_d;
        end else if (Start && state_q == S_RUN && (idx_q != IDX_LAST || WRAP != 0)) begin
            oh_q <= {oh_q[DEPTH-2:0], oh_q[DEPTH-1]};
        end
    end

    assign slot_oh = oh_q;
`endif

    assign WriteReg    = BASE_A + AW'(idx_q);
    assign wrap        = wrap_q;
    assign done        = done_q;
    assign busy        = Start && !done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_write_addr_seq.sv
// Bench for write_addr_seq: a wrapping default instance and a saturating
// DEPTH=4/BASE=0 instance share stimulus and are checked against a slot model.
module tb_write_addr_seq;

    logic       clk;
    logic       rst_n;
    logic       Start;
    logic       clear;
    logic       load;
    logic [7:0] load_idx;

    logic [3:0] d_wr, s_wr;
    logic       d_wrap, d_done, d_busy, d_st;
    logic       s_wrap, s_done, s_busy, s_st;
`ifdef WRITE_ADDR_SEQ_ONEHOT_EN
    logic [14:0] d_oh;
    logic [3:0]  s_oh;
`endif

    write_addr_seq dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .clear(clear), .load(load),
        .load_idx(load_idx), .WriteReg(d_wr), .wrap(d_wrap), .done(d_done),
        .busy(d_busy), .dbg_state_o(d_st)
`ifdef WRITE_ADDR_SEQ_ONEHOT_EN
        , .slot_oh(d_oh)
`endif
    );

    write_addr_seq #(.DEPTH(4), .AW(4), .BASE(0), .WRAP(0)) dut_sat (
        .clk(clk), .rst_n(rst_n), .Start(Start), .clear(clear), .load(load),
        .load_idx(load_idx), .WriteReg(s_wr), .wrap(s_wrap), .done(s_done),
        .busy(s_busy), .dbg_state_o(s_st)
`ifdef WRITE_ADDR_SEQ_ONEHOT_EN
        , .slot_oh(s_oh)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // expected per cycle: {d_wr[4], d_wrap, d_done, d_busy, s_wr[4], s_wrap, s_done, s_busy, s_state, d_state}
    logic [15:0] exp_q[$];

    int d_slot = 0;
    bit d_stuck = 0;
    int s_slot = 0;
    bit s_stuck = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: slot counts 0..depth-1; wrap mode returns to 0, saturate mode sticks.
    function automatic void model_step(input int depth, input bit wrap_mode, input bit st,
                                       input bit cl, input bit ld, input int li,
                                       inout int slot, inout bit stuck, output bit w);
        w = 1'b0;
        if (cl) begin
            slot  = 0;
            stuck = 1'b0;
        end else if (ld) begin
            slot  = (li >= depth) ? depth - 1 : li;
            stuck = 1'b0;
        end else if (st && !stuck) begin
            if (slot < depth - 1) begin
                slot = slot + 1;
            end else if (wrap_mode) begin
                slot = 0;
                w    = 1'b1;
            end else begin
                stuck = 1'b1;
            end
        end
    endfunction

    // driver: one clock of stimulus, expected outcome queued for the monitor
    task automatic cycle(input bit st, input bit cl, input bit ld, input int li);
        bit dw, sw;
        @(negedge clk);
        Start    = st;
        clear    = cl;
        load     = ld;
        load_idx = 8'(li);
        model_step(15, 1'b1, st, cl, ld, li, d_slot, d_stuck, dw);
        model_step(4, 1'b0, st, cl, ld, li, s_slot, s_stuck, sw);
        exp_q.push_back({4'(d_slot + 1), dw, d_stuck, st && !d_stuck,
                         4'(s_slot), sw, s_stuck, st && !s_stuck, s_stuck, d_stuck});
    endtask

    // asynchronous reset pulse between edges, checked while rst_n is low
    task automatic reset_pulse();
        @(negedge clk);
        Start = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_d_wr", d_wr, 1);
        check("rst_d_wrap", d_wrap, 0);
        check("rst_d_done", d_done, 0);
        check("rst_s_wr", s_wr, 0);
        check("rst_s_wrap", s_wrap, 0);
        check("rst_s_done", s_done, 0);
        #1 rst_n = 1'b1;
        d_slot  = 0;
        d_stuck = 1'b0;
        s_slot  = 0;
        s_stuck = 1'b0;
    endtask

    // scoreboard monitor
    always @(posedge clk) begin : monitor
        logic [15:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("d_wr", d_wr, e[15:12]);
            check("d_wrap", d_wrap, e[11]);
            check("d_done", d_done, e[10]);
            check("d_busy", d_busy, e[9]);
            check("s_wr", s_wr, e[8:5]);
            check("s_wrap", s_wrap, e[4]);
            check("s_done", s_done, e[3]);
            check("s_busy", s_busy, e[2]);
            check("s_state", s_st, e[1]);
            check("d_state", d_st, e[0]);
`ifdef WRITE_ADDR_SEQ_ONEHOT_EN
            check("d_oh", d_oh, 32'(15'(1) << (e[15:12] - 4'd1)));
            check("s_oh", s_oh, 32'(4'(1) << e[8:5]));
`endif
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n    = 1'b0;
        Start    = 1'b0;
        clear    = 1'b0;
        load     = 1'b0;
        load_idx = 8'd0;
        #3;
        check("init_d_wr", d_wr, 1);
        check("init_d_wrap", d_wrap, 0);
        check("init_s_wr", s_wr, 0);
        check("init_s_done", s_done, 0);
        #4 rst_n = 1'b1;

        // full lap: 2..15 then back to 1 with a wrap pulse; saturating copy sticks at 3
        for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // toggled Start from reset
        reset_pulse();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // load clamp, and clear beating load
        cycle(0, 0, 1, 200);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 200);
        cycle(0, 1, 1, 5);
        cycle(0, 0, 1, 255);
        cycle(0, 0, 1, 2);
        cycle(1, 0, 0, 0);

        // reset mid-sequence at WriteReg=9
        cycle(0, 0, 1, 8);
        reset_pulse();
        cycle(1, 0, 0, 0);

        // reset right after a wrap pulse
        cycle(0, 0, 1, 13);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        reset_pulse();
        cycle(1, 0, 0, 0);

        // randomized mix, biased toward advancing
        for (int i = 0; i < 400; i++) begin
            bit st, cl, ld;
            int li;
            st = ($urandom_range(0, 9) < 7);
            cl = ($urandom_range(0, 19) == 0);
            ld = ($urandom_range(0, 11) == 0);
            li = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 16);
            if ($urandom_range(0, 99) == 0) reset_pulse();
            cycle(st, cl, ld, li);
        end

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
